// File: rtl/store_unit_pkg.sv
// Shared store-path types: store uops, acks, and memory-side requests.
// Also holds the store unit state enum.
package store_unit_pkg;

  localparam int ID_W = 4;

  typedef logic [ID_W-1:0] StID_t;

  typedef struct packed {
    logic        valid;
    StID_t       id;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  wmask;
    logic        isMMIO;
  } ST_UOp;

  typedef struct packed {
    logic  valid;
    StID_t id;
  } ST_Ack;

  typedef enum logic [2:0] {
    IDLE,
    MISS_REQ,
    MISS_WAIT,
    MMIO_REQ,
    MMIO_WAIT
  } StUnitState;

  typedef struct packed {
    logic        valid;
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  wmask;
  } CacheWrReq;

  typedef struct packed {
    logic        valid;
    logic [29:0] addr;
  } MissReq;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  wmask;
  } MMIOWrReq;

endpackage

// File: rtl/store_unit.sv
// Store unit: takes committed stores one at a time and writes them to
// the dcache (with miss refill + replay) or MMIO; acks each in order.
// Ports: IN_uopSt/OUT_stall (queue side), OUT_stAck (ack pulse),
// OUT_cacheReq/IN_cacheGrant/IN_cacheHit (dcache write port),
// OUT_missReq/IN_missReady/IN_missDone (refill), OUT_mmioReq/
// IN_mmioReady/IN_mmioAck (MMIO bus).
module store_unit
  import store_unit_pkg::*;
#(
  parameter int ID_BITS = $bits(StID_t)
) (
  input  logic      clk,
  input  logic      rst,
  input  ST_UOp     IN_uopSt,
  output logic      OUT_stall,
  output ST_Ack     OUT_stAck,
  output CacheWrReq OUT_cacheReq,
  input  logic      IN_cacheGrant,
  input  logic      IN_cacheHit,
  output MissReq    OUT_missReq,
  input  logic      IN_missReady,
  input  logic      IN_missDone,
  output MMIOWrReq  OUT_mmioReq,
  input  logic      IN_mmioReady,
  input  logic      IN_mmioAck
);

  ST_UOp              cur_q, cur_d;
  StUnitState         state_q, state_d;
  logic               ackVld_q, ackVld_d;
  logic [ID_BITS-1:0] ackId_q, ackId_d;
  logic               complete;

  always_comb begin
    state_d      = state_q;
    complete     = 1'b0;
    OUT_cacheReq = '0;
    OUT_missReq  = '0;
    OUT_mmioReq  = '0;
    unique case (state_q)
      IDLE: begin
        if (cur_q.valid) begin
          // wmask == 0 marks a special op: ack without memory access
          if (cur_q.wmask == 4'b0) begin
            complete = 1'b1;
          end else if (cur_q.isMMIO) begin
            state_d = MMIO_REQ;
          end else begin
            OUT_cacheReq.valid = 1'b1;
            OUT_cacheReq.addr  = cur_q.addr[31:2];
            OUT_cacheReq.data  = cur_q.data;
            OUT_cacheReq.wmask = cur_q.wmask;
            if (IN_cacheGrant) begin
              if (IN_cacheHit) complete = 1'b1;
              else             state_d  = MISS_REQ;
            end
          end
        end
      end
      MISS_REQ: begin
        OUT_missReq.valid = 1'b1;
        OUT_missReq.addr  = cur_q.addr[31:2];
        if (IN_missReady) state_d = MISS_WAIT;
      end
      MISS_WAIT: begin
        // line is resident: replay the same store through the port
        if (IN_missDone) state_d = IDLE;
      end
      MMIO_REQ: begin
        OUT_mmioReq.valid = 1'b1;
        OUT_mmioReq.addr  = cur_q.addr;
        OUT_mmioReq.data  = cur_q.data;
        OUT_mmioReq.wmask = cur_q.wmask;
        if (IN_mmioReady) state_d = MMIO_WAIT;
      end
      MMIO_WAIT: begin
        if (IN_mmioAck) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign OUT_stall = cur_q.valid && !complete;

  always_comb begin
    cur_d    = cur_q;
    ackVld_d = complete;
    ackId_d  = ID_BITS'(cur_q.id);
    if (!OUT_stall) begin
      cur_d = IN_uopSt.valid ? IN_uopSt : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q    <= '0;
      state_q  <= IDLE;
      ackVld_q <= 1'b0;
      ackId_q  <= '0;
    end else begin
      cur_q    <= cur_d;
      state_q  <= state_d;
      ackVld_q <= ackVld_d;
      ackId_q  <= ackId_d;
    end
  end

  assign OUT_stAck.valid = ackVld_q;
  assign OUT_stAck.id    = StID_t'(ackId_q);

  a_missDone: assert property (@(posedge clk) disable iff (rst)
    IN_missDone |-> state_q == MISS_WAIT);
  a_mmioAck: assert property (@(posedge clk) disable iff (rst)
    IN_mmioAck |-> state_q == MMIO_WAIT);

endmodule

// File: tb/tb_store_unit.sv
// Randomized + directed bench for store_unit.
// Memory-side agent with configurable delays; in-order scoreboard.
module tb_store_unit;
  import store_unit_pkg::*;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  ST_UOp     IN_uopSt = '0;
  logic      OUT_stall;
  ST_Ack     OUT_stAck;
  CacheWrReq OUT_cacheReq;
  logic      IN_cacheGrant = 1'b0;
  logic      IN_cacheHit = 1'b0;
  MissReq    OUT_missReq;
  logic      IN_missReady = 1'b0;
  logic      IN_missDone = 1'b0;
  MMIOWrReq  OUT_mmioReq;
  logic      IN_mmioReady = 1'b0;
  logic      IN_mmioAck = 1'b0;

  store_unit dut (
    .clk          (clk),
    .rst          (rst),
    .IN_uopSt     (IN_uopSt),
    .OUT_stall    (OUT_stall),
    .OUT_stAck    (OUT_stAck),
    .OUT_cacheReq (OUT_cacheReq),
    .IN_cacheGrant(IN_cacheGrant),
    .IN_cacheHit  (IN_cacheHit),
    .OUT_missReq  (OUT_missReq),
    .IN_missReady (IN_missReady),
    .IN_missDone  (IN_missDone),
    .OUT_mmioReq  (OUT_mmioReq),
    .IN_mmioReady (IN_mmioReady),
    .IN_mmioAck   (IN_mmioAck)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // agent configuration, written only by the stimulus process
  int cfg_epoch = 0;
  int cfg_rnd = 0;
  int cfg_deny = 0;
  int cfg_miss = 0;
  int cfg_mr = 0;
  int cfg_md = 1;
  int cfg_or = 0;
  int cfg_od = 1;

  always begin : agent
    int seen, deny_left, miss_left;
    int mr_wait, md_cnt, or_wait, od_cnt;
    logic g, h;
    seen = -1; deny_left = 0; miss_left = 0;
    mr_wait = -1; md_cnt = 0; or_wait = -1; od_cnt = 0;
    forever begin
      @(posedge clk); #2;
      if (seen != cfg_epoch) begin
        seen = cfg_epoch;
        deny_left = cfg_deny;
        miss_left = cfg_miss;
      end
      if (rst) begin
        mr_wait = -1; md_cnt = 0; or_wait = -1; od_cnt = 0;
        IN_cacheGrant = 0; IN_cacheHit = 0;
        IN_missReady = 0; IN_missDone = 0;
        IN_mmioReady = 0; IN_mmioAck = 0;
      end else begin
        if (OUT_cacheReq.valid) begin
          if (deny_left > 0) begin
            g = 0; deny_left--;
          end else begin
            g = cfg_rnd != 0 ? ($urandom_range(0, 3) != 0) : 1'b1;
          end
          if (g && miss_left > 0) begin
            h = 0; miss_left--;
          end else begin
            h = cfg_rnd != 0 ? ($urandom_range(0, 2) != 0) : 1'b1;
          end
        end else begin
          g = cfg_rnd != 0 ? 1'($urandom_range(0, 1)) : 1'b0;
          h = cfg_rnd != 0 ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        IN_cacheGrant = g;
        IN_cacheHit = h;
        IN_missDone = 0;
        if (md_cnt > 0) begin
          md_cnt--;
          if (md_cnt == 0) IN_missDone = 1;
        end
        IN_missReady = 0;
        if (OUT_missReq.valid) begin
          if (mr_wait < 0)
            mr_wait = cfg_rnd != 0 ? $urandom_range(0, 3) : cfg_mr;
          if (mr_wait == 0) begin
            IN_missReady = 1;
            mr_wait = -1;
            md_cnt = cfg_rnd != 0 ? $urandom_range(1, 8) : cfg_md;
          end else mr_wait--;
        end
        IN_mmioAck = 0;
        if (od_cnt > 0) begin
          od_cnt--;
          if (od_cnt == 0) IN_mmioAck = 1;
        end
        IN_mmioReady = 0;
        if (OUT_mmioReq.valid) begin
          if (or_wait < 0)
            or_wait = cfg_rnd != 0 ? $urandom_range(0, 3) : cfg_or;
          if (or_wait == 0) begin
            IN_mmioReady = 1;
            or_wait = -1;
            od_cnt = cfg_rnd != 0 ? $urandom_range(1, 8) : cfg_od;
          end else or_wait--;
        end
      end
    end
  end

  // scoreboard: accepted stores in order, with per-store port usage
  ST_UOp exp_q[$];
  int cyc = 0;
  int acc_at[16];
  int ack_at[16];
  int n_acc = 0, n_ack = 0;
  int n_creq = 0, n_mreq = 0, n_oreq = 0, n_stall = 0;
  int oack_cyc = 0;

  always begin : mon
    ST_UOp u, f;
    int wr_n, mm_n;
    wr_n = 0; mm_n = 0;
    forever begin
      @(posedge clk); #6;
      cyc++;
      if (rst) begin
        exp_q.delete();
        wr_n = 0; mm_n = 0;
      end else begin
        if (OUT_stAck.valid) begin
          ack_at[OUT_stAck.id] = cyc;
          n_ack++;
          if (exp_q.size() == 0) begin
            chk("ack_spurious", 1, 0);
          end else begin
            u = exp_q.pop_front();
            chk("ack_id", 64'(OUT_stAck.id), 64'(u.id));
            chk("ack_writes", wr_n,
                (u.wmask != 0 && !u.isMMIO) ? 1 : 0);
            chk("ack_mmio", mm_n,
                (u.wmask != 0 && u.isMMIO) ? 1 : 0);
          end
          wr_n = 0; mm_n = 0;
        end
        f = exp_q.size() > 0 ? exp_q[0] : '0;
        if (OUT_cacheReq.valid) begin
          n_creq++;
          chk("creq_kind", 64'(f.valid && !f.isMMIO && f.wmask != 0), 1);
          chk("creq_addr", 64'(OUT_cacheReq.addr), 64'(f.addr[31:2]));
          chk("creq_data", 64'(OUT_cacheReq.data), 64'(f.data));
          chk("creq_mask", 64'(OUT_cacheReq.wmask), 64'(f.wmask));
          if (IN_cacheGrant && IN_cacheHit) wr_n++;
        end
        if (OUT_missReq.valid) begin
          n_mreq++;
          chk("mreq_kind", 64'(f.valid && !f.isMMIO && f.wmask != 0), 1);
          chk("mreq_addr", 64'(OUT_missReq.addr), 64'(f.addr[31:2]));
        end
        if (OUT_mmioReq.valid) begin
          n_oreq++;
          chk("oreq_kind", 64'(f.valid && f.isMMIO && f.wmask != 0), 1);
          chk("oreq_addr", 64'(OUT_mmioReq.addr), 64'(f.addr));
          chk("oreq_data", 64'(OUT_mmioReq.data), 64'(f.data));
          chk("oreq_mask", 64'(OUT_mmioReq.wmask), 64'(f.wmask));
          if (IN_mmioReady) mm_n++;
        end
        if (IN_mmioAck) oack_cyc = cyc;
        if (OUT_stall) n_stall++;
        if (IN_uopSt.valid && !OUT_stall) begin
          exp_q.push_back(IN_uopSt);
          acc_at[IN_uopSt.id] = cyc;
          n_acc++;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic ST_UOp mk(input int id, input logic [31:0] a,
                               input logic [31:0] d,
                               input logic [3:0] m, input logic io);
    ST_UOp u;
    u.valid = 1'b1;
    u.id = StID_t'(id);
    u.addr = a;
    u.data = d;
    u.wmask = m;
    u.isMMIO = io;
    return u;
  endfunction

  // present a store and hold it until accepted; returns at +2
  task automatic send(input ST_UOp u);
    int n;
    n = 0;
    IN_uopSt = u;
    #5;
    while (OUT_stall && n < 300) begin
      @(posedge clk); #7;
      n++;
    end
    if (n >= 300) chk("send_timeout", n, 0);
    @(posedge clk); #2;
    IN_uopSt = '0;
  endtask

  task automatic set_cfg(input int rnd, input int deny,
                         input int miss, input int mr, input int md,
                         input int orr, input int od);
    cfg_rnd = rnd; cfg_deny = deny; cfg_miss = miss;
    cfg_mr = mr; cfg_md = md; cfg_or = orr; cfg_od = od;
    cfg_epoch++;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_stall"}, 64'(OUT_stall), 0);
    chk({tag, "_ack"}, 64'(|OUT_stAck), 0);
    chk({tag, "_creq"}, 64'(|OUT_cacheReq), 0);
    chk({tag, "_mreq"}, 64'(|OUT_missReq), 0);
    chk({tag, "_oreq"}, 64'(|OUT_mmioReq), 0);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int s0, s1, s2, a0, c0, n;
    ST_UOp u;
    rst = 1;
    step(3);
    #5;
    chk_idle_outputs("reset");
    step(1);
    rst = 0;
    step(1);

    // back-to-back hits
    set_cfg(0, 0, 0, 0, 1, 0, 1);
    s0 = n_stall;
    for (int i = 0; i < 4; i++)
      send(mk(i, 32'h100 + 32'(4 * i), $urandom, 4'hF, 1'b0));
    step(4);
    for (int i = 0; i < 4; i++)
      chk("hit_ack_cyc", ack_at[i], acc_at[0] + 2 + i);
    chk("hit_no_stall", n_stall - s0, 0);

    // three cycles without grant
    set_cfg(0, 3, 0, 0, 1, 0, 1);
    s0 = n_stall;
    send(mk(5, 32'h200, $urandom, 4'h3, 1'b0));
    step(8);
    chk("deny_lat", ack_at[5] - acc_at[5], 5);
    chk("deny_stall", n_stall - s0, 3);

    // miss, refill, replay; younger store waits
    set_cfg(0, 0, 1, 2, 10, 0, 1);
    s0 = n_mreq;
    send(mk(7, 32'h2000, $urandom, 4'hC, 1'b0));
    send(mk(8, 32'h3000, $urandom, 4'hF, 1'b0));
    step(4);
    chk("miss_lat", ack_at[7] - acc_at[7], 16);
    chk("miss_req_cyc", n_mreq - s0, 3);
    chk("miss_order", acc_at[8], ack_at[7] - 1);
    chk("miss_next_lat", ack_at[8] - acc_at[8], 2);

    // MMIO store
    set_cfg(0, 0, 0, 0, 1, 2, 5);
    s0 = n_creq;
    s1 = n_oreq;
    send(mk(2, 32'h1000_0000, $urandom, 4'hF, 1'b1));
    step(14);
    chk("mmio_lat", ack_at[2] - acc_at[2], 10);
    chk("mmio_ack_after", ack_at[2], oack_cyc + 1);
    chk("mmio_no_creq", n_creq - s0, 0);
    chk("mmio_req_cyc", n_oreq - s1, 3);

    // special op
    set_cfg(0, 0, 0, 0, 1, 0, 1);
    s0 = n_creq; s1 = n_mreq; s2 = n_oreq;
    send(mk(3, 32'h300, $urandom, 4'h0, 1'b0));
    step(4);
    chk("spec_lat", ack_at[3] - acc_at[3], 2);
    chk("spec_no_port", (n_creq - s0) + (n_mreq - s1) + (n_oreq - s2), 0);

    // randomized traffic
    set_cfg(1, 0, 0, 0, 1, 0, 1);
    a0 = n_ack;
    c0 = n_acc;
    for (int k = 0; k < 250; k++) begin
      step($urandom_range(0, 2));
      u = mk($urandom_range(0, 15), $urandom, $urandom,
             4'($urandom_range(0, 15)),
             $urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0) u.wmask = 4'h0;
      send(u);
    end
    n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      step(1);
      n++;
    end
    step(2);
    chk("rnd_drain", exp_q.size(), 0);
    chk("rnd_ack_count", n_ack - a0, n_acc - c0);

    // reset while waiting for a refill
    set_cfg(0, 0, 1, 0, 30, 0, 1);
    send(mk(9, 32'h4000, $urandom, 4'hF, 1'b0));
    n = 0;
    while (!OUT_missReq.valid && n < 20) begin
      step(1);
      n++;
    end
    chk("rst_reach_miss", n < 20, 1);
    step(1);
    chk("mw_stall", 64'(OUT_stall), 1);
    rst = 1;
    step(1);
    #5;
    chk_idle_outputs("midrst");
    step(1);
    rst = 0;
    set_cfg(0, 0, 0, 0, 1, 0, 1);
    a0 = n_ack;
    step(1);
    send(mk(10, 32'h500, $urandom, 4'hF, 1'b0));
    step(4);
    chk("post_rst_lat", ack_at[10] - acc_at[10], 2);
    chk("post_rst_acks", n_ack - a0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
